// File: rtl/pixel_fifo_filler_pkg.sv
// Shared types for the pixel FIFO producer.
// Framebuffer geometry defaults, pixel type and FSM states.
package pixel_fifo_filler_pkg;

  localparam int DEF_ADDR_W    = 21;
  localparam int DEF_FB_WIDTH  = 320;
  localparam int DEF_FB_HEIGHT = 240;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FLUSH
  } state_e;

endpackage

// File: rtl/pixel_fifo_filler_if.sv
// SRAM arbiter read port: request/ready plus in-order response.
// The filler drives the master side, the arbiter the slave side.
interface pixel_fifo_filler_if
  import pixel_fifo_filler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              sram_rd_req;
  logic [ADDR_W-1:0] sram_rd_addr;
  logic              sram_rd_ready;
  logic              sram_rd_valid;
  pixel_t            sram_rd_data;

  modport master (
    output sram_rd_req,
    output sram_rd_addr,
    input  sram_rd_ready,
    input  sram_rd_valid,
    input  sram_rd_data
  );

  modport slave (
    input  sram_rd_req,
    input  sram_rd_addr,
    output sram_rd_ready,
    output sram_rd_valid,
    output sram_rd_data
  );

endinterface

// File: rtl/pixel_fifo_filler_addr_gen.sv
// Raster address walker: x, line repeat, y and line base.
// Line base steps by FB_WIDTH so no multiplier is needed.
module fb_raster_addr_gen
  import pixel_fifo_filler_pkg::*;
#(
  parameter int                FB_WIDTH    = DEF_FB_WIDTH,
  parameter int                FB_HEIGHT   = DEF_FB_HEIGHT,
  parameter int                LINE_REPEAT = 2,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int XW = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int RW = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
  localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;

  logic [XW-1:0]     x_q, x_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic x_wrap, rep_wrap, y_wrap;

  assign x_wrap   = (x_q == XW'(FB_WIDTH - 1));
  assign rep_wrap = (rep_q == RW'(LINE_REPEAT - 1));
  assign y_wrap   = (y_q == YW'(FB_HEIGHT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      rep_q  <= '0;
      y_q    <= '0;
      base_q <= BASE_ADDR;
    end else begin
      x_q    <= x_d;
      rep_q  <= rep_d;
      y_q    <= y_d;
      base_q <= base_d;
    end
  end

  always_comb begin
    x_d    = x_q;
    rep_d  = rep_q;
    y_d    = y_q;
    base_d = base_q;
    if (clr) begin
      x_d    = '0;
      rep_d  = '0;
      y_d    = '0;
      base_d = BASE_ADDR;
    end else if (adv) begin
      if (!x_wrap) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = '0;
        if (!rep_wrap) begin
          rep_d = rep_q + 1'b1;
        end else begin
          rep_d  = '0;
          y_d    = y_wrap ? '0 : y_q + 1'b1;
          base_d = base_q + ADDR_W'(FB_WIDTH);
        end
      end
    end
  end

  assign addr = base_q + ADDR_W'(x_q);
  assign last = x_wrap && rep_wrap && y_wrap;

endmodule

// File: rtl/pixel_fifo_filler.sv
// Pixel FIFO producer: streams the framebuffer from SRAM into the
// pixel FIFO with credit-based flow control and abortable frames.
module pixel_fifo_filler
  import pixel_fifo_filler_pkg::*;
#(
  parameter int                FB_WIDTH        = DEF_FB_WIDTH,
  parameter int                FB_HEIGHT       = DEF_FB_HEIGHT,
  parameter int                LINE_REPEAT     = 2,
  parameter int                ADDR_W          = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
  parameter int                FIFO_DEPTH      = 512,
  parameter int                LEVEL_W         = 10,
  parameter int                MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_start,
  pixel_fifo_filler_if.master rd,
  input  logic [LEVEL_W-1:0]  fifo_level,
  output logic                fifo_wr_en,
  output pixel_t              fifo_wr_data,
  output logic                fifo_clr,
  output logic                busy,
  output logic                frame_done,
  output logic                protocol_err
);

  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = LEVEL_W + OW + 1;

  state_e            state_q, state_d;
  logic [OW-1:0]     out_q, out_d;
  logic              hold_q, hold_d;
  logic              wr_en_q, wr_en_d;
  pixel_t            wr_data_q, wr_data_d;
  logic              clr_q, clr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              req, accept, rsp_ok, abort, start;
  logic              credit, last;
  logic [SUM_W-1:0]  fill;
  logic [ADDR_W-1:0] addr;

  fb_raster_addr_gen #(
    .FB_WIDTH    (FB_WIDTH),
    .FB_HEIGHT   (FB_HEIGHT),
    .LINE_REPEAT (LINE_REPEAT),
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR)
  ) u_addr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .adv     (accept),
    .addr    (addr),
    .last    (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      out_q     <= '0;
      hold_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      hold_q    <= hold_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      clr_q     <= clr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (frame_start) state_d = FETCH;
      FETCH: begin
        if (frame_start)         state_d = FLUSH;
        else if (accept && last) state_d = DRAIN;
      end
      DRAIN: begin
        if (frame_start) state_d = FLUSH;
        else if (done_q) state_d = IDLE;
      end
      FLUSH: if (out_q == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    abort  = frame_start &&
             (state_q == FETCH || state_q == DRAIN);
    start  = (state_q == IDLE && frame_start) ||
             (state_q == FLUSH && out_q == '0);
    // Bytes already committed to the FIFO: stored, in flight, being written.
    fill   = SUM_W'(fifo_level) + SUM_W'(out_q) + SUM_W'(wr_en_q);
    credit = (fill < SUM_W'(FIFO_DEPTH)) &&
             (out_q < OW'(MAX_OUTSTANDING));
    req    = (state_q == FETCH) && (hold_q || credit);
    accept = req && rd.sram_rd_ready;
    rsp_ok = rd.sram_rd_valid && (out_q != '0);

    hold_d = req && !rd.sram_rd_ready;
    out_d  = out_q;
    unique case (1'b1)
      (accept && !rsp_ok): out_d = out_q + 1'b1;
      (rsp_ok && !accept): out_d = out_q - 1'b1;
      default:             out_d = out_q;
    endcase

    wr_en_d   = rsp_ok && (state_q != FLUSH) && !abort;
    wr_data_d = rsp_ok ? rd.sram_rd_data : wr_data_q;
    clr_d     = start;
    done_d    = (state_q == DRAIN) && !frame_start &&
                rsp_ok && (out_q == OW'(1));
    err_d     = err_q || (rd.sram_rd_valid && out_q == '0);
  end

  assign rd.sram_rd_req  = req;
  assign rd.sram_rd_addr = addr;
  assign fifo_wr_en      = wr_en_q;
  assign fifo_wr_data    = wr_data_q;
  assign fifo_clr        = clr_q;
  assign busy            = (state_q != IDLE);
  assign frame_done      = done_q;
  assign protocol_err    = err_q;

endmodule

// File: doc/pixel_fifo_filler.md
Name: pixel_fifo_filler

Overview:
- Producer end of the pixel FIFO. The display side pops one byte per visible pixel from this FIFO; this block refills it.
- Runs in the SRAM/arbiter clock domain. It streams the R3G3B2 framebuffer out of external SRAM through the arbiter's read port and pushes the bytes into the pixel FIFO in raster order.
- Each framebuffer line is fetched LINE_REPEAT times to produce vertical doubling. Horizontal doubling is done by the consumer.

Parameters:
- FB_WIDTH, 320, framebuffer pixels per line
- FB_HEIGHT, 240, framebuffer lines
- LINE_REPEAT, 2, times each line is streamed
- ADDR_W, 21, SRAM byte address width
- BASE_ADDR, 0, framebuffer start address
- FIFO_DEPTH, 512, pixel FIFO capacity in bytes
- LEVEL_W, 10, fill-level width; must hold FIFO_DEPTH
- MAX_OUTSTANDING, 4, limit on in-flight SRAM reads

Ports:
- clk  in  1  SRAM-domain clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; start (or restart) a frame fetch. Already synchronized to clk.
- sram_rd_req  out  1  read request
- sram_rd_addr  out  ADDR_W  read byte address
- sram_rd_ready  in  1  arbiter accepts the request this cycle
- sram_rd_valid  in  1  read data returned; in order, variable latency >= 1
- sram_rd_data  in  8  returned pixel byte
- fifo_level  in  LEVEL_W  current FIFO occupancy, write-side view
- fifo_wr_en  out  1  push one byte
- fifo_wr_data  out  8  byte to push
- fifo_clr  out  1  one-cycle FIFO flush
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when the last byte of the frame has been pushed
- protocol_err  out  1  sticky; set on a response with nothing outstanding

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, all counters 0.
- Counters:
  - x: 0..FB_WIDTH-1
  - rep: 0..LINE_REPEAT-1
  - y: 0..FB_HEIGHT-1
  - line_base (ADDR_W): starts at BASE_ADDR; += FB_WIDTH when rep wraps. No multiplier.
  - sram_rd_addr = line_base + x.
- Counter advance: x advances on every accepted request (sram_rd_req && sram_rd_ready). On x wrap, rep advances. On rep wrap, y and line_base advance.
- Bytes per frame = FB_WIDTH*LINE_REPEAT*FB_HEIGHT (153600 at defaults).
- outstanding counter:
  - +1 on accept, -1 on sram_rd_valid, unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING.
- Credit rule: sram_rd_req = 1 only in FETCH, and only when both hold:
  - fifo_level + outstanding + fifo_wr_en < FIFO_DEPTH
  - outstanding < MAX_OUTSTANDING
- Request holding: once sram_rd_req is asserted, req and addr stay stable until ready. Exception: abort via frame_start.
- Write path: sram_rd_valid in cycle N gives fifo_wr_en = 1 with fifo_wr_data = sram_rd_data in cycle N+1. The FIFO is never written when full.
- FSM:
  - IDLE: on frame_start, pulse fifo_clr, reset counters, go to FETCH.
  - FETCH: issue requests. When the last address is accepted, go to DRAIN.
  - DRAIN: wait for outstanding == 0 and the final write. Pulse frame_done together with the last fifo_wr_en cycle, then go to IDLE.
  - FLUSH: entered from FETCH or DRAIN on frame_start. Drop sram_rd_req immediately, even without a grant. Discard responses (no fifo_wr_en) until outstanding == 0. Then pulse fifo_clr, reset counters, go to FETCH. A frame_start received during FLUSH is absorbed.
- frame_start in the same cycle as the last accept: abort wins, go to FLUSH.
- Response with outstanding == 0: ignored, protocol_err set; cleared only by reset.
- Async reset mid-frame: everything returns to reset values immediately. The arbiter is reset by the same reset_n.

Decomposition:
- Shared package: ADDR_W, pixel type (8-bit R3G3B2), FB_WIDTH/FB_HEIGHT defaults, FSM state enum {IDLE, FETCH, DRAIN, FLUSH}.
- One natural sub-module: fb_raster_addr_gen (x/rep/y/line_base counters; outputs addr and last flag).

Test Plan:
- Ideal arbiter (ready = 1, latency 2, fifo_level = 0), tiny params 4x2, LINE_REPEAT=2 -> addresses 0,1,2,3,0,1,2,3,4,5,6,7,4,5,6,7. 16 writes. frame_done on the 16th write.
- Consumer stalled with fifo_level held at FIFO_DEPTH-3 -> at most 3 bytes issued/pushed. Never a write at level FIFO_DEPTH.
- Arbiter latency 10, ready = 1 -> outstanding peaks at 4. Data stays in order. No dropped bytes.
- frame_start at request #7 with 3 outstanding -> req drops the next cycle. 3 responses arrive with no fifo_wr_en. Then fifo_clr, and a restart at BASE_ADDR.
- sram_rd_valid pulsed while idle -> no write, protocol_err = 1 until reset_n low.
- reset_n asserted mid-DRAIN -> all outputs 0 asynchronously (before the next clk edge). After release, busy stays 0 until frame_start.
